seq_player: RTL
===============

# seq_player

Parametrised Simon Says sequence source. It emits a replayable pseudo-random stream of button indices from an internal Galois LFSR, one symbol per valid/ready handshake, up to a growing round length. It sits between the game controller and the LED/tone playback and input-compare logic. It succeeds the fixed 256-entry memory-file reader with a seedable, arbitrary-length, handshaked source.

## Interface
- NUM_CH, 4, number of buttons; power of two, 2..16
- LFSR_W, 16, LFSR width; one of 8, 16, 24, 32
- MAX_LEN, 32, maximum round length, ≥1
- SEED, 16'hACE1, default nonzero seed, LFSR_W bits
- Derived: SYM_W = $clog2(NUM_CH), LEN_W = $clog2(MAX_LEN+1)

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous, active-low reset
- seed_load  in  1  pulse; start a new game using seed_in
- seed_in  in  LFSR_W  seed; value 0 means "use SEED"
- rewind  in  1  pulse; restart playback from symbol 0
- extend  in  1  pulse; increase round length by 1
- sym_ready  in  1  consumer accepts sym
- sym_valid  out  1  sym is valid
- sym  out  SYM_W  current button index
- pos  out  LEN_W  index of the current symbol
- round_len  out  LEN_W  current round length
- round_done  out  1  level; all round_len symbols have been emitted
- full  out  1  round_len == MAX_LEN

## Operation
- Registers:
  - base: seed of the current game
  - lfsr: running state
  - pos
  - round_len
  - prev: last emitted symbol
  - state
- States and transitions:
  - IDLE: sym_valid=0, round_done=0. Goes to PLAY on rewind.
  - PLAY: sym_valid=1. On sym_valid&sym_ready:
    - pos+1
    - lfsr advances SYM_W Galois steps
    - prev ← sym
    - if old pos+1 == old round_len, go to DONE
  - DONE: sym_valid=0, round_done=1. Goes to PLAY on rewind.
- rewind (any state): lfsr←base, pos←0, prev cleared, state←PLAY.
- seed_load (any state):
  - base and lfsr ← (seed_in==0 ? SEED : seed_in)
  - pos←0, round_len←1, state←IDLE
- extend: round_len+1 when full=0; ignored when full=1. Does not change pos or state. A DONE→PLAY re-entry still requires rewind.
- Symbol: candidate = lfsr[SYM_W-1:0].
- Replay determinism: after any rewind, the stream is identical to the previous stream from the same base for all overlapping positions.
- Priority within one cycle, highest first: seed_load, rewind, handshake. extend is applied in parallel.
  - seed_load+rewind: new game, then PLAY from the new seed.
  - seed_load+extend: round_len=1, extend is dropped.
  - A handshake compares against the pre-extend round_len.

## Timing
- Reset values:
  - state=IDLE, lfsr=base=SEED, pos=0, round_len=1, prev=0
  - outputs: sym_valid=0, round_done=0, full=(MAX_LEN==1)
- All outputs are driven from registers only; there is no combinational input-to-output path.
- Control pulse at edge k takes effect in cycle k+1. Example: sym_valid=1 in the cycle after the rewind edge.
- Throughput: one symbol per cycle while sym_ready=1.
- sym is stable while sym_valid=1 and sym_ready=0.
- round_done asserts in the cycle after the last handshake.

## Configuration
- SEQ_PLAYER_NO_REPEAT_EN
- Defined: when pos>0 and candidate==prev, sym = (candidate+1) mod NUM_CH. No two consecutive symbols are equal, and replay stays deterministic.
- Undefined: sym = candidate and the prev register is removed.

## Structure
- seq_player_pkg holds:
  - state enum (IDLE, PLAY, DONE)
  - Galois tap-constant function indexed by LFSR_W (8:'hB8, 16:'hB400, 24:'hE10000, 32:'hA3000000)
- Sub-module seq_lfsr contains:
  - LFSR_W register with load port and value
  - step input advancing SYM_W steps in one cycle, unrolled
  - tap selection from the package
- Elaboration assertions: NUM_CH power of two, legal LFSR_W, nonzero SEED.

## Test plan
- Reset:
  - Stimulus: release n_rst.
  - Required: sym_valid=0, round_done=0, round_len=1, pos=0, full=0.
- Single round:
  - Stimulus: rewind, then sym_ready=1.
  - Required: exactly one handshake; round_done=1 next cycle with pos=1.
- Replay:
  - Stimulus: extend×4 (round_len=5), rewind, consume 5 symbols and record them; rewind and consume again.
  - Required: identical 5-symbol list.
- Backpressure:
  - Stimulus: hold sym_ready=0 for 3 cycles mid-round.
  - Required: sym and pos are unchanged.
- Zero seed:
  - Stimulus: seed_load with seed_in=0 versus seed_load with seed_in=SEED.
  - Required: identical streams.
- Saturation and macro:
  - Stimulus: extend ×40 with MAX_LEN=32.
  - Required: round_len=32, full=1.
  - With SEQ_PLAYER_NO_REPEAT_EN: no consecutive equal symbols over 32 symbols.

Source files
------------

// File: rtl/seq_player_pkg.sv
// Shared definitions for the Simon Says sequence player.
// Holds the playback state encoding and the Galois tap table.
// No logic; imported by seq_lfsr and seq_player.
package seq_player_pkg;

  // Playback states, kept as plain constants for legacy-compatible encodings
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_PLAY = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Right-shift Galois tap masks for the supported widths; 0 marks an unsupported width
  function automatic logic [31:0] lfsr_taps(input int unsigned width);
    logic [31:0] taps;
    taps = 32'h0;
    case (width)
      8:       taps = 32'h0000_00B8;
      16:      taps = 32'h0000_B400;
      24:      taps = 32'h00E1_0000;
      32:      taps = 32'hA300_0000;
      default: taps = 32'h0;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/seq_lfsr.sv
// Galois LFSR that advances STEPS shifts per step pulse, with a parallel load.
// Latency: load/step take effect on the next clock edge; value is the register itself.
// Backpressure: none; the caller only pulses step on an accepted symbol.
module seq_lfsr
  import seq_player_pkg::*;
#(
  parameter int              LFSR_W = 16,
  parameter int              STEPS  = 2,
  parameter int              OUT_W  = 2,
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              step,
  output logic [OUT_W-1:0]  value
);

  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_nxt;

  // Unrolled multi-shift so one accepted symbol consumes STEPS fresh bits
  always_comb begin
    lfsr_nxt = lfsr_q;
    for (int i = 0; i < STEPS; i++) begin
      lfsr_nxt = lfsr_nxt[0] ? ((lfsr_nxt >> 1) ^ TAPS) : (lfsr_nxt >> 1);
    end
  end

  // State register: load wins over step so rewind/new-game always resynchronise
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      lfsr_q <= SEED;
    end else if (load) begin
      lfsr_q <= load_val;
    end else if (step) begin
      lfsr_q <= lfsr_nxt;
    end
  end

  assign value = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/seq_player.sv
// Seedable, replayable Simon Says symbol source; SEQ_PLAYER_NO_REPEAT_EN forbids equal neighbours.
// Latency: control pulses act on the next cycle; one symbol per cycle while sym_ready is high.
// Backpressure: sym_valid/sym_ready handshake; sym and pos hold while sym_ready is low.
module seq_player
  import seq_player_pkg::*;
#(
  parameter int                NUM_CH  = 4,
  parameter int                LFSR_W  = 16,
  parameter int                MAX_LEN = 32,
  parameter logic [LFSR_W-1:0] SEED    = 16'hACE1,
  localparam int               SYM_W   = $clog2(NUM_CH),
  localparam int               LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              rewind,
  input  logic              extend,
  input  logic              sym_ready,
  output logic              sym_valid,
  output logic [SYM_W-1:0]  sym,
  output logic [LEN_W-1:0]  pos,
  output logic [LEN_W-1:0]  round_len,
  output logic              round_done,
  output logic              full
);

  if (NUM_CH < 2 || NUM_CH > 16 || (NUM_CH & (NUM_CH - 1)) != 0) begin : g_bad_num_ch
    $error("seq_player: NUM_CH must be a power of two in 2..16");
  end
  if (lfsr_taps(LFSR_W) == 32'h0) begin : g_bad_lfsr_w
    $error("seq_player: LFSR_W must be 8, 16, 24 or 32");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("seq_player: SEED must be nonzero");
  end
  if (MAX_LEN < 1) begin : g_bad_max_len
    $error("seq_player: MAX_LEN must be at least 1");
  end

  state_t            state_q;
  logic [LFSR_W-1:0] base_q;
  logic [LEN_W-1:0]  pos_q;
  logic [LEN_W-1:0]  len_q;
  logic [SYM_W-1:0]  cand;
  logic [LFSR_W-1:0] seed_eff;
  logic [LEN_W-1:0]  pos_nxt;
  logic              hs;
  logic              is_full;

  // A zero seed would lock the LFSR, so it selects the built-in default instead
  assign seed_eff = (seed_in == '0) ? SEED : seed_in;
  assign hs       = (state_q == ST_PLAY) && sym_ready;
  assign pos_nxt  = pos_q + LEN_W'(1);
  assign is_full  = (len_q == LEN_W'(MAX_LEN));

  seq_lfsr #(
    .LFSR_W (LFSR_W),
    .STEPS  (SYM_W),
    .OUT_W  (SYM_W),
    .SEED   (SEED)
  ) u_lfsr (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (seed_load | rewind),
    .load_val (seed_load ? seed_eff : base_q),
    .step     (hs),
    .value    (cand)
  );

  // Game seed, playback position and state; seed_load outranks rewind outranks handshake
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      base_q  <= SEED;
      pos_q   <= '0;
    end else if (seed_load) begin
      base_q  <= seed_eff;
      pos_q   <= '0;
      state_q <= rewind ? ST_PLAY : ST_IDLE;
    end else if (rewind) begin
      pos_q   <= '0;
      state_q <= ST_PLAY;
    end else if (hs) begin
      pos_q <= pos_nxt;
      // Compared against the length before any same-cycle extend
      if (pos_nxt == len_q) begin
        state_q <= ST_DONE;
      end
    end
  end

  // Round length grows by extend, saturates at MAX_LEN, and restarts at 1 per game
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      len_q <= LEN_W'(1);
    end else if (seed_load) begin
      len_q <= LEN_W'(1);
    end else if (extend && !is_full) begin
      len_q <= len_q + LEN_W'(1);
    end
  end

`ifdef SEQ_PLAYER_NO_REPEAT_EN
  logic [SYM_W-1:0] prev_q;

  // Last emitted symbol, cleared on every restart so replays see the same history
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prev_q <= '0;
    end else if (seed_load || rewind) begin
      prev_q <= '0;
    end else if (hs) begin
      prev_q <= sym;
    end
  end

  // Bump a repeated candidate to the next button; power-of-two NUM_CH wraps naturally
  always_comb begin
    sym = cand;
    if (pos_q != '0 && cand == prev_q) begin
      sym = cand + SYM_W'(1);
    end
  end
`else
  assign sym = cand;
`endif

  assign sym_valid  = (state_q == ST_PLAY);
  assign round_done = (state_q == ST_DONE);
  assign pos        = pos_q;
  assign round_len  = len_q;
  assign full       = is_full;

endmodule
